// File: rtl/aes_inv_key_gen.sv
// Inverse AES-128 key schedule: loads the round-10 key and streams round keys
// 10 down to 0 over a valid/ready handshake. SubWord is computed by an
// external S-box shared through sub_o/sub_i, with SBOX_LAT cycles of latency.
// Optional build macro AES_INV_KEY_CACHE_EN adds an 11-entry round-key cache
// with a registered random-access read port.
module aes_inv_key_gen #(
  parameter int unsigned SBOX_LAT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [127:0] key10_i,
  output logic         ready_o,
  output logic [127:0] key_o,
  output logic [3:0]   rnd_o,
  output logic         key_valid_o,
  input  logic         key_ready_i,
  output logic         done_o,
  output logic [31:0]  sub_o,
  input  logic [31:0]  sub_i
`ifdef AES_INV_KEY_CACHE_EN
  ,
  input  logic [3:0]   rd_rnd_i,
  output logic [127:0] rd_key_o,
  output logic         rd_vld_o
`endif
);

  localparam int unsigned KEY_W = 128;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned RND_W = 4;
  localparam int unsigned RCON_W = 8;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OUT  = 2'd1,
    ST_SUB  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic [RND_W-1:0]    rnd_q, rnd_d;
  logic [RCON_W-1:0]   rcon_q, rcon_d;
  logic [WORD_W-1:0]   sub_q, sub_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;

  logic [WORD_W-1:0]   w0, w1, w2, w3;
  logic [WORD_W-1:0]   p0, p1, p2, p3;
  logic                sub_last;

  // Previous-round words recovered from the current round key and S-box result
  always_comb begin
    w0 = key_q[127:96];
    w1 = key_q[95:64];
    w2 = key_q[63:32];
    w3 = key_q[31:0];
    p3 = w3 ^ w2;
    p2 = w2 ^ w1;
    p1 = w1 ^ w0;
    p0 = w0 ^ sub_i ^ {rcon_q, 24'h0};
    sub_last = (cnt_q == CNT_W'(SBOX_LAT));
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    rcon_d  = rcon_q;
    sub_d   = sub_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    ready_d = ready_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (load_i) begin
          key_d   = key10_i;
          rnd_d   = RND_W'(10);
          rcon_d  = 8'h36;
          valid_d = 1'b1;
          ready_d = 1'b0;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (key_ready_i) begin
          valid_d = 1'b0;
          if (rnd_q != '0) begin
            sub_d   = {p3[23:0], p3[31:24]};
            cnt_d   = '0;
            state_d = ST_SUB;
          end else begin
            ready_d = 1'b1;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_SUB: begin
        if (sub_last) begin
          key_d   = {p0, p1, p2, p3};
          rnd_d   = rnd_q - RND_W'(1);
          rcon_d  = rcon_q[0] ? (((rcon_q ^ 8'h1B) >> 1) | 8'h80) : (rcon_q >> 1);
          sub_d   = '0;
          valid_d = 1'b1;
          state_d = ST_OUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        valid_d = 1'b0;
        sub_d   = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      rnd_q   <= '0;
      rcon_q  <= 8'h36;
      sub_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
      rcon_q  <= rcon_d;
      sub_q   <= sub_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign ready_o     = ready_q;
  assign key_o       = key_q;
  assign rnd_o       = rnd_q;
  assign key_valid_o = valid_q;
  assign done_o      = done_q;
  assign sub_o       = sub_q;

`ifdef AES_INV_KEY_CACHE_EN
  localparam int unsigned NKEYS = 11;

  logic [KEY_W-1:0] cache_q [NKEYS];
  logic [KEY_W-1:0] cache_d [NKEYS];
  logic [NKEYS-1:0] cvld_q, cvld_d;
  logic [KEY_W-1:0] rd_key_q, rd_key_d;
  logic             rd_vld_q, rd_vld_d;
  logic             load_acc;
  logic             cache_wr;

  // Cache every emitted key at its round index; serve registered reads
  always_comb begin
    load_acc = (state_q == ST_IDLE) && load_i;
    cache_wr = load_acc || ((state_q == ST_SUB) && sub_last);
    cache_d  = cache_q;
    cvld_d   = cvld_q;
    if (load_acc) begin
      cvld_d = '0;
    end
    if (cache_wr) begin
      cache_d[rnd_d] = key_d;
      cvld_d[rnd_d]  = 1'b1;
    end
    rd_key_d = '0;
    rd_vld_d = 1'b0;
    if (rd_rnd_i <= RND_W'(10)) begin
      rd_key_d = cache_q[rd_rnd_i];
      rd_vld_d = cvld_q[rd_rnd_i];
    end
  end

  // Cache data storage; validity tracked separately so data needs no reset
  always_ff @(posedge clk) begin
    cache_q <= cache_d;
  end

  // Cache valid bits and read port registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cvld_q   <= '0;
      rd_key_q <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      cvld_q   <= cvld_d;
      rd_key_q <= rd_key_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  assign rd_key_o = rd_key_q;
  assign rd_vld_o = rd_vld_q;
`endif

endmodule

// File: tb/tb_aes_inv_key_gen.sv
// Directed bench for aes_inv_key_gen: FIPS-197 key schedule walked backwards,
// backpressure, ignored loads, mid-run reset, and an SBOX_LAT=2 instance.
module tb_aes_inv_key_gen;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  // FIPS-197 AES-128 round keys, index = round
  localparam logic [127:0] EXP [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  logic         clk = 1'b0;
  logic         rst;
  logic         load_i, key_ready_i;
  logic [127:0] key10_i;
  logic         ready_o, key_valid_o, done_o;
  logic [127:0] key_o;
  logic [3:0]   rnd_o;
  logic [31:0]  sub_o, sub_i;

  logic         l_load_i, l_key_ready_i;
  logic         l_ready_o, l_key_valid_o, l_done_o;
  logic [127:0] l_key_o;
  logic [3:0]   l_rnd_o;
  logic [31:0]  l_sub_o, l_sub_i, l_d1, l_d2;

  logic [3:0]   rd_rnd_i;
  logic [127:0] rd_key_o, l_rd_key_o;
  logic         rd_vld_o, l_rd_vld_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] sbox_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rotw(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Zero-latency S-box for the default instance, two-stage pipe for the other
  always_comb sub_i = sbox_word(sub_o);
  always @(posedge clk) begin
    l_d1 <= sbox_word(l_sub_o);
    l_d2 <= l_d1;
  end
  assign l_sub_i = l_d2;

  aes_inv_key_gen u_dut (
    .clk(clk), .rst(rst), .load_i(load_i), .key10_i(key10_i),
    .ready_o(ready_o), .key_o(key_o), .rnd_o(rnd_o), .key_valid_o(key_valid_o),
    .key_ready_i(key_ready_i), .done_o(done_o), .sub_o(sub_o), .sub_i(sub_i)
`ifdef AES_INV_KEY_CACHE_EN
    , .rd_rnd_i(rd_rnd_i), .rd_key_o(rd_key_o), .rd_vld_o(rd_vld_o)
`endif
  );

  aes_inv_key_gen #(.SBOX_LAT(2)) u_lat (
    .clk(clk), .rst(rst), .load_i(l_load_i), .key10_i(key10_i),
    .ready_o(l_ready_o), .key_o(l_key_o), .rnd_o(l_rnd_o), .key_valid_o(l_key_valid_o),
    .key_ready_i(l_key_ready_i), .done_o(l_done_o), .sub_o(l_sub_o), .sub_i(l_sub_i)
`ifdef AES_INV_KEY_CACHE_EN
    , .rd_rnd_i(rd_rnd_i), .rd_key_o(l_rd_key_o), .rd_vld_o(l_rd_vld_o)
`endif
  );

`ifndef AES_INV_KEY_CACHE_EN
  assign rd_key_o = '0;
  assign rd_vld_o = 1'b0;
  assign l_rd_key_o = '0;
  assign l_rd_vld_o = 1'b0;
`endif

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle load pulse from IDLE; K10 must be presented right after
  task automatic do_load();
    load_i = 1'b1;
    step();
    load_i = 1'b0;
    chk("load_valid", 128'(key_valid_o), 128'(1));
    chk("load_key", key_o, EXP[10]);
    chk("load_rnd", 128'(rnd_o), 128'(10));
    chk("load_ready", 128'(ready_o), 128'(0));
    chk("load_done", 128'(done_o), 128'(0));
  endtask

  // Walk keys 10..0; ends on the cycle where done_o is expected high
  task automatic run_keys(input int rdy_pct, input bit noise);
    for (int n = 10; n >= 0; n--) begin
      int  w;
      int  guard;
      logic acc;
      w = 0;
      while (key_valid_o !== 1'b1 && w < 10) begin
        chk($sformatf("sub_o_r%0d", n), 128'(sub_o), 128'(rotw(EXP[n][31:0])));
        key_ready_i = noise ? 1'($urandom_range(1)) : 1'b1;
        load_i      = noise ? 1'($urandom_range(1)) : 1'b0;
        step();
        w++;
      end
      load_i = 1'b0;
      chk($sformatf("valid_r%0d", n), 128'(key_valid_o), 128'(1));
      chk($sformatf("key_r%0d", n), key_o, EXP[n]);
      chk($sformatf("rnd_r%0d", n), 128'(rnd_o), 128'(n));
      chk($sformatf("sub_idle_r%0d", n), 128'(sub_o), 128'(0));
      if (n < 10) chk($sformatf("spacing_r%0d", n), 128'(w + 1), 128'(2));
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 200) begin
        key_ready_i = (int'($urandom_range(99)) < rdy_pct) ? 1'b1 : 1'b0;
        load_i      = noise ? 1'($urandom_range(1)) : 1'b0;
        acc = key_ready_i;
        step();
        guard++;
        if (!acc) begin
          chk($sformatf("stall_key_r%0d", n), key_o, EXP[n]);
          chk($sformatf("stall_rnd_r%0d", n), 128'(rnd_o), 128'(n));
          chk($sformatf("stall_valid_r%0d", n), 128'(key_valid_o), 128'(1));
        end
      end
      load_i = 1'b0;
      key_ready_i = 1'b0;
      chk($sformatf("accept_r%0d", n), 128'(acc), 128'(1));
    end
    chk("done_pulse", 128'(done_o), 128'(1));
    chk("done_ready", 128'(ready_o), 128'(1));
    chk("done_valid", 128'(key_valid_o), 128'(0));
  endtask

  initial begin
    int g;
    rst = 1'b1;
    load_i = 1'b0;
    key_ready_i = 1'b0;
    key10_i = EXP[10];
    l_load_i = 1'b0;
    l_key_ready_i = 1'b0;
    rd_rnd_i = '0;
    step();
    step();
    chk("rst_ready", 128'(ready_o), 128'(1));
    chk("rst_valid", 128'(key_valid_o), 128'(0));
    chk("rst_key", key_o, 128'(0));
    chk("rst_rnd", 128'(rnd_o), 128'(0));
    chk("rst_done", 128'(done_o), 128'(0));
    chk("rst_sub", 128'(sub_o), 128'(0));
    rst = 1'b0;
    step();
    chk("idle_ready", 128'(ready_o), 128'(1));

    // Full stream with the consumer always ready
    do_load();
    run_keys(100, 0);

    // Load on the done_o cycle, then backpressure with stray loads
    do_load();
    run_keys(30, 1);
    step();
    chk("done_one_cycle", 128'(done_o), 128'(0));
    chk("idle_ready2", 128'(ready_o), 128'(1));

    // Reset mid-stream at round 5
    do_load();
    key_ready_i = 1'b1;
    g = 0;
    while (!(key_valid_o === 1'b1 && rnd_o == 4'd5) && g < 100) begin
      step();
      g++;
    end
    chk("reach_rnd5", 128'(rnd_o), 128'(5));
    rst = 1'b1;
    key_ready_i = 1'b0;
    step();
    rst = 1'b0;
    chk("mid_rst_ready", 128'(ready_o), 128'(1));
    chk("mid_rst_valid", 128'(key_valid_o), 128'(0));
    chk("mid_rst_key", key_o, 128'(0));
    chk("mid_rst_rnd", 128'(rnd_o), 128'(0));
    step();
    chk("mid_rst_no_done", 128'(done_o), 128'(0));
    do_load();
    run_keys(100, 1);

`ifdef AES_INV_KEY_CACHE_EN
    for (int i = 0; i <= 10; i++) begin
      rd_rnd_i = 4'(i);
      step();
      chk($sformatf("cache_key_%0d", i), rd_key_o, EXP[i]);
      chk($sformatf("cache_vld_%0d", i), 128'(rd_vld_o), 128'(1));
    end
    rd_rnd_i = 4'd12;
    step();
    chk("cache_oob_key", rd_key_o, 128'(0));
    chk("cache_oob_vld", 128'(rd_vld_o), 128'(0));
    do_load();
    rd_rnd_i = 4'd3;
    step();
    chk("cache_clr_vld", 128'(rd_vld_o), 128'(0));
    rd_rnd_i = 4'd10;
    step();
    chk("cache_k10_vld", 128'(rd_vld_o), 128'(1));
    chk("cache_k10_key", rd_key_o, EXP[10]);
`endif

    // SBOX_LAT=2 instance: spacing 4 cycles, sub_o held through SUB
    chk("lat_idle_ready", 128'(l_ready_o), 128'(1));
    l_load_i = 1'b1;
    step();
    l_load_i = 1'b0;
    l_key_ready_i = 1'b1;
    chk("lat_key_r10", l_key_o, EXP[10]);
    chk("lat_rnd_r10", 128'(l_rnd_o), 128'(10));
    for (int n = 9; n >= 0; n--) begin
      int w;
      step();
      w = 0;
      while (l_key_valid_o !== 1'b1 && w < 10) begin
        chk($sformatf("lat_sub_r%0d", n), 128'(l_sub_o), 128'(rotw(EXP[n][31:0])));
        step();
        w++;
      end
      chk($sformatf("lat_spacing_r%0d", n), 128'(w + 1), 128'(4));
      chk($sformatf("lat_key_r%0d", n), l_key_o, EXP[n]);
      chk($sformatf("lat_rnd_r%0d", n), 128'(l_rnd_o), 128'(n));
    end
    step();
    l_key_ready_i = 1'b0;
    chk("lat_done", 128'(l_done_o), 128'(1));
    chk("lat_ready", 128'(l_ready_o), 128'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
